// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter_if
// Description : Requester-side and APB-side signal bundle for apb_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;

  logic                      psel;
  logic                      penable;
  logic [ADDR_W-1:0]         paddr;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic                      pready;
  logic [DATA_W-1:0]         prdata;

  // Arbiter view: consumes requests, drives the APB master port.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, paddr, pwrite, pwdata,
    input  pready, prdata
  );

  // Environment view: requesters plus the APB slave fabric.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, paddr, pwrite, pwdata,
    output pready, prdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin arbiter sharing one APB master port among NUM_REQ
//               requesters. Define APB_ARB_TIMEOUT_EN to build the ACCESS
//               wait-state timeout (limit set by TIMEOUT).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input wire                clk,
  input wire                rst_n,
  apb_req_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("apb_req_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("apb_req_arbiter: TIMEOUT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_found;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_winner;
  logic [IDX_W-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    r_tmo_cnt;
  logic                r_rsp_err;
`endif

  // Scan from r_rr_ptr upward with wrap-around; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_grant_oh  = '0;
    w_owner_oh  = '0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner == IDX_W'(k)) begin
        w_grant_oh[k] = w_found;
        w_sel_write   = bus.req_write[k];
        w_sel_addr    = bus.req_addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata   = bus.req_wdata[k*DATA_W +: DATA_W];
      end
      w_owner_oh[k] = (r_owner == IDX_W'(k));
    end
  end

  assign w_ptr_next = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_paddr     <= w_sel_addr;
            r_pwrite    <= w_sel_write;
            r_pwdata    <= w_sel_write ? w_sel_wdata : '0;
            r_psel      <= 1'b1;
            r_req_ready <= w_grant_oh;
            r_owner     <= w_winner;
            r_rr_ptr    <= w_ptr_next;
            r_state     <= ST_SETUP;
`ifdef APB_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready has priority over a timeout hit in the same cycle.
          if (bus.pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= w_owner_oh;
            r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
            r_state     <= ST_IDLE;
`ifdef APB_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= w_owner_oh;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo_cnt   <= r_tmo_cnt + CNT_W'(1);
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
`ifdef APB_ARB_TIMEOUT_EN
  assign bus.rsp_err   = r_rsp_err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire
